// File: rtl/spi_ss_sequencer_if.sv
// Bundle of request handshake, timing configuration, shift-engine handshake
// and slave-select outputs for spi_ss_sequencer.
interface spi_ss_sequencer_if #(
    parameter int NUM_SS = 8,
    parameter int CNT_W  = 8
);
    localparam int SEL_W = (NUM_SS > 2) ? $clog2(NUM_SS) : 1;

    logic              req;
    logic [SEL_W-1:0]  sel;
    logic              cont;
    logic [CNT_W-1:0]  setup_cyc;
    logic [CNT_W-1:0]  hold_cyc;
    logic [CNT_W-1:0]  idle_cyc;
    logic              xfer_done;
    logic [NUM_SS-1:0] ss_n;
    logic              go;
    logic              ack;
    logic              busy;
    logic              sel_err;

    // Requester / shift-engine side
    modport master (
        output req, sel, cont, setup_cyc, hold_cyc, idle_cyc, xfer_done,
        input  ss_n, go, ack, busy, sel_err
    );

    // Sequencer side
    modport slave (
        input  req, sel, cont, setup_cyc, hold_cyc, idle_cyc, xfer_done,
        output ss_n, go, ack, busy, sel_err
    );
endinterface

// File: rtl/spi_ss_sequencer.sv
// Slave-select sequencer for the SPI master: accepts a request for one slave,
// drops its active-low select, times CS setup / hold / idle gaps with a single
// down-counter, issues a one-cycle go to the shift engine, and can chain
// back-to-back transfers on the same slave without releasing CS.
module spi_ss_sequencer #(
    parameter int NUM_SS = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_ss_sequencer_if.slave bus
);
    localparam int SEL_W = (NUM_SS > 2) ? $clog2(NUM_SS) : 1;
    // NUM_SS widened by one bit so that NUM_SS = 2**SEL_W still fits.
    localparam logic [SEL_W:0] NUM_SS_EXT = (SEL_W+1)'(NUM_SS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACTIVE = 3'd2,
        HOLD   = 3'd3,
        GAP    = 3'd4
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [SEL_W-1:0]  idx_reg;
    logic [NUM_SS-1:0] ss_n_reg;
    logic              go_reg;

    logic              sel_ok;
    logic              idle_accept;
    logic              cont_accept;
    logic [NUM_SS-1:0] sel_onehot;

    // One-hot decode of the requested slave index
    generate
        for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_sel_dec
            assign sel_onehot[gi] = (bus.sel == SEL_W'(gi));
        end
    endgenerate

    assign sel_ok      = ({1'b0, bus.sel} < NUM_SS_EXT);
    assign idle_accept = (state_reg == IDLE) && bus.req && sel_ok;
    // Chaining only when the new request targets the slave already selected.
    assign cont_accept = (state_reg == ACTIVE) && bus.xfer_done && bus.cont &&
                         bus.req && (bus.sel == idx_reg);

    assign bus.ack     = idle_accept || cont_accept;
    assign bus.sel_err = (state_reg == IDLE) && bus.req && !sel_ok;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.ss_n    = ss_n_reg;
    assign bus.go      = go_reg;

    // Sequencer FSM: state, shared down-counter, latched index and registered
    // outputs. go is set one cycle ahead so it coincides with the last SETUP
    // cycle (counter reaching 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            ss_n_reg  <= '1;
            go_reg    <= 1'b0;
        end else begin
            go_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ss_n_reg <= '1;
                    if (idle_accept) begin
                        state_reg <= SETUP;
                        cnt_reg   <= bus.setup_cyc;
                        idx_reg   <= bus.sel;
                        ss_n_reg  <= ~sel_onehot;
                        go_reg    <= (bus.setup_cyc == '0);
                    end
                end
                SETUP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ACTIVE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                        go_reg  <= (cnt_reg == CNT_W'(1));
                    end
                end
                ACTIVE: begin
                    if (bus.xfer_done) begin
                        if (cont_accept) begin
                            // Single-cycle SETUP, CS stays low
                            state_reg <= SETUP;
                            cnt_reg   <= '0;
                            go_reg    <= 1'b1;
                        end else if (bus.hold_cyc != '0) begin
                            state_reg <= HOLD;
                            cnt_reg   <= bus.hold_cyc - 1'b1;
                        end else if (bus.idle_cyc != '0) begin
                            state_reg <= GAP;
                            cnt_reg   <= bus.idle_cyc - 1'b1;
                            ss_n_reg  <= '1;
                        end else begin
                            state_reg <= IDLE;
                            ss_n_reg  <= '1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        ss_n_reg <= '1;
                        if (bus.idle_cyc != '0) begin
                            state_reg <= GAP;
                            cnt_reg   <= bus.idle_cyc - 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                GAP: begin
                    ss_n_reg <= '1;
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ss_n_reg  <= '1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ss_sequencer.sv
// Directed bench for spi_ss_sequencer: an 8-slave instance exercises timing,
// continuation, reset and spurious xfer_done; a 5-slave instance covers
// out-of-range slave indices.
module tb_spi_ss_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_ss_sequencer_if #(.NUM_SS(8), .CNT_W(8)) b8 ();
    spi_ss_sequencer_if #(.NUM_SS(5), .CNT_W(8)) b5 ();

    spi_ss_sequencer #(.NUM_SS(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    spi_ss_sequencer #(.NUM_SS(5), .CNT_W(8)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string t, input int c, input logic a, input logic g,
                        input logic bz, input logic [7:0] s);
        check($sformatf("%s_ack_c%0d", t, c),  {31'b0, b8.ack},  {31'b0, a});
        check($sformatf("%s_go_c%0d", t, c),   {31'b0, b8.go},   {31'b0, g});
        check($sformatf("%s_busy_c%0d", t, c), {31'b0, b8.busy}, {31'b0, bz});
        check($sformatf("%s_ss_n_c%0d", t, c), {24'b0, b8.ss_n}, {24'b0, s});
        $display("%s c%0d ack=%0b go=%0b busy=%0b ss_n=%02h", t, c, b8.ack, b8.go, b8.busy, b8.ss_n);
    endtask

    task automatic clear_inputs();
        b8.req = 0; b8.sel = '0; b8.cont = 0; b8.xfer_done = 0;
        b8.setup_cyc = '0; b8.hold_cyc = '0; b8.idle_cyc = '0;
        b5.req = 0; b5.sel = '0; b5.cont = 0; b5.xfer_done = 0;
        b5.setup_cyc = '0; b5.hold_cyc = '0; b5.idle_cyc = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk8("rst", 0, 1'b0, 1'b0, 1'b0, 8'hFF);
        check("rst_sel_err8", {31'b0, b8.sel_err}, 32'd0);
        check("rst_ss_n5", {27'b0, b5.ss_n}, 32'h1F);
        check("rst_busy5", {31'b0, b5.busy}, 32'd0);
    endtask

    initial begin
        clear_inputs();

        // Basic timing: setup=2 hold=1 idle=3 sel=5, xfer_done in cycle 10
        do_reset();
        b8.setup_cyc = 8'd2; b8.hold_cyc = 8'd1; b8.idle_cyc = 8'd3; b8.sel = 3'd5;
        for (int c = 0; c <= 15; c++) begin
            b8.req       = (c == 0) || (c == 15);
            b8.xfer_done = (c == 10);
            #1;
            chk8("basic", c, (c == 0) || (c == 15), c == 3, (c >= 1) && (c <= 14),
                 ((c >= 1) && (c <= 11)) ? 8'hDF : 8'hFF);
            check($sformatf("basic_sel_err_c%0d", c), {31'b0, b8.sel_err}, 32'd0);
            next_cycle();
        end

        // All counts zero, sel=0, xfer_done in cycle 5
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            b8.req       = (c == 0);
            b8.xfer_done = (c == 5);
            #1;
            chk8("zero", c, c == 0, c == 1, (c >= 1) && (c <= 5),
                 ((c >= 1) && (c <= 5)) ? 8'hFE : 8'hFF);
            next_cycle();
        end

        // Continuation on sel=3: setup=1 hold=2 idle=1, req held through cycle 6
        do_reset();
        b8.setup_cyc = 8'd1; b8.hold_cyc = 8'd2; b8.idle_cyc = 8'd1;
        b8.sel = 3'd3; b8.cont = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            b8.req       = (c <= 6);
            b8.xfer_done = (c == 6) || (c == 11);
            #1;
            chk8("cont", c, (c == 0) || (c == 6), (c == 2) || (c == 7),
                 (c >= 1) && (c <= 14), ((c >= 1) && (c <= 13)) ? 8'hF7 : 8'hFF);
            next_cycle();
        end

        // Continuation refused (sel changes to 4): normal HOLD/GAP, then accepted in IDLE
        do_reset();
        b8.setup_cyc = 8'd1; b8.hold_cyc = 8'd2; b8.idle_cyc = 8'd1;
        b8.cont = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            b8.sel       = (c == 0) ? 3'd3 : 3'd4;
            b8.req       = (c <= 10);
            b8.xfer_done = (c == 6);
            #1;
            chk8("nocont", c, (c == 0) || (c == 10), c == 2,
                 ((c >= 1) && (c <= 9)) || (c == 11),
                 (c == 11) ? 8'hEF : (((c >= 1) && (c <= 8)) ? 8'hF7 : 8'hFF));
            next_cycle();
        end

        // Out-of-range index on the 5-slave instance
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            b5.req = (c == 0) || (c == 2) || (c == 3);
            b5.sel = (c == 0) ? 3'd6 : ((c == 2) ? 3'd5 : 3'd4);
            #1;
            check($sformatf("err_sel_err_c%0d", c), {31'b0, b5.sel_err},
                  {31'b0, (c == 0) || (c == 2)});
            check($sformatf("err_ack_c%0d", c), {31'b0, b5.ack}, {31'b0, c == 3});
            check($sformatf("err_busy_c%0d", c), {31'b0, b5.busy}, {31'b0, c == 4});
            check($sformatf("err_ss_n_c%0d", c), {27'b0, b5.ss_n},
                  (c == 4) ? 32'h0F : 32'h1F);
            $display("err c%0d sel_err=%0b ack=%0b busy=%0b ss_n=%02h",
                     c, b5.sel_err, b5.ack, b5.busy, b5.ss_n);
            next_cycle();
        end

        // Reset while ACTIVE on sel=2; later xfer_done must do nothing
        do_reset();
        b8.sel = 3'd2;
        for (int c = 0; c <= 5; c++) begin
            b8.req       = (c == 0);
            b8.xfer_done = (c == 3);
            rst          = (c == 2);
            #1;
            chk8("midrst", c, c == 0, c == 1, (c == 1) || (c == 2),
                 ((c == 1) || (c == 2)) ? 8'hFB : 8'hFF);
            next_cycle();
        end
        rst = 1'b0;

        // Spurious xfer_done during SETUP (setup=4), real one in cycle 9
        do_reset();
        b8.setup_cyc = 8'd4; b8.sel = 3'd1;
        for (int c = 0; c <= 11; c++) begin
            b8.req       = (c == 0);
            b8.xfer_done = (c == 2) || (c == 9);
            #1;
            chk8("spur", c, c == 0, c == 5, (c >= 1) && (c <= 9),
                 ((c >= 1) && (c <= 9)) ? 8'hFD : 8'hFF);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_ss_sequencer.md
# spi_ss_sequencer

Parametrised, clocked slave-select controller for the SPI master, generalising the fixed 8-way select distributor. It accepts a transaction request with a slave index and drives one active-low select line for that slave. It enforces programmable CS-to-clock setup, post-transfer hold and inter-transaction idle gaps. It hands a start pulse to the shift engine and supports back-to-back transfers without releasing the select line.

## Interface
- NUM_SS, 8: number of slave-select lines, legal range 2..256
- CNT_W, 8: width of the setup/hold/idle count inputs
- SEL_W, derived = max(1, ceil(log2(NUM_SS))): width of `sel` (localparam, not overridable)

Ports (clock and reset first):
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  transaction request (level), held until `ack`
- sel  in  SEL_W  slave index, sampled at acceptance
- cont  in  1  continuous mode: chain the next transfer on the same slave without releasing CS
- setup_cyc  in  CNT_W  extra CS-low cycles before `go`
- hold_cyc  in  CNT_W  CS-low cycles after `xfer_done`
- idle_cyc  in  CNT_W  minimum all-high cycles between transactions
- xfer_done  in  1  one-cycle pulse from shift engine: last bit complete
- ss_n  out  NUM_SS  active-low selects, registered, at most one low
- go  out  1  one-cycle start pulse to shift engine
- ack  out  1  one-cycle request-accepted pulse (combinational from registered state and inputs)
- busy  out  1  high whenever state != IDLE
- sel_err  out  1  one-cycle pulse: request with `sel >= NUM_SS` rejected

## Operation
- States: IDLE, SETUP, ACTIVE, HOLD, GAP. A single down-counter (CNT_W bits) times SETUP/HOLD/GAP.
- Count inputs are sampled only on state entry. A state of length N loads N-1 and exits when the counter is 0. Zero-length HOLD/GAP states are skipped.
- IDLE behaviour:
  - `ss_n` is all ones.
  - If `req=1` and `sel<NUM_SS`: `ack=1`, latch `sel`, go to SETUP (length `setup_cyc+1`), and drive `ss_n[sel]` low from the next cycle.
  - If `req=1` and `sel>=NUM_SS`: `sel_err=1`, `ack=0`, stay in IDLE.
- SETUP: `ss_n[latched]` low. `go=1` only in the last SETUP cycle, then go to ACTIVE.
- ACTIVE: `ss_n[latched]` low. The block waits for `xfer_done`. When `xfer_done=1`:
  - If `cont=1`, `req=1` and `sel` equals the latched index: `ack=1`, then SETUP with length 1, ignoring `setup_cyc`. CS stays low and `go` fires in the next cycle.
  - Otherwise, if `hold_cyc>0`: go to HOLD.
  - Otherwise, if `idle_cyc>0`: go to GAP, with `ss_n` all high next cycle.
  - Otherwise: go to IDLE, with `ss_n` all high next cycle.
- HOLD: `ss_n[latched]` low for `hold_cyc` cycles, then GAP (or IDLE if `idle_cyc=0`). `ss_n` is all high from the first cycle after HOLD.
- GAP: `ss_n` all high for `idle_cyc` cycles, then IDLE. `req` is not accepted in HOLD or GAP.
- `xfer_done` outside ACTIVE is ignored. In ACTIVE, a `req` that does not meet the continuation condition is left pending, without `ack`.
- `sel_err` can only occur in IDLE. It never occurs when NUM_SS is a power of two.

## Timing
- Reset values (the cycle after `rst` is sampled high, at any state): state IDLE, `ss_n` all ones, `go=0`, `ack=0`, `busy=0`, `sel_err=0`, counter 0, latched index 0.
- Reset mid-transaction: CS is released the next cycle and no `go` is issued. The shift engine is reset by the same `rst`.
- Acceptance cycle A (`ack=1`): `ss_n` falls in A+1, `go` in A+1+`setup_cyc`, ACTIVE from A+2+`setup_cyc`.
- `xfer_done` in cycle D: `ss_n` rises in D+1+`hold_cyc`, `busy` falls in D+1+`hold_cyc`+`idle_cyc`, next `ack` earliest in the same cycle as `busy` falls.
- Continuation: `ack` in D, `go` in D+1, `ss_n` continuously low.
- `ss_n` is glitch-free: driven from a register, with no combinational path from inputs.

## Test plan
- NUM_SS=8, setup=2, hold=1, idle=3, sel=5, req in cycle 0:
  - `ack` in cycle 0; `ss_n=8'b1101_1111` cycles 1–11; `go` in cycle 3.
  - `xfer_done` in cycle 10 -> `ss_n=8'hFF` from cycle 12; `busy=0` and re-`ack` possible in cycle 15.
- All counts 0, sel=0, req in cycle 0 -> `ss_n=8'hFE` and `go` in cycle 1; `xfer_done` in cycle 5 -> `ss_n=8'hFF`, `busy=0` in cycle 6.
- Continuation:
  - sel=3, cont=1, req held, same sel at `xfer_done` in cycle D -> `ack` in D, `go` in D+1, `ss_n[3]` never high.
  - Repeat with sel=4 -> no `ack`, normal HOLD/GAP, then accepted in IDLE.
- NUM_SS=5, sel=6, req in cycle 0 -> `sel_err` in cycle 0 only, no `ack`, `ss_n=5'b11111`, `busy=0`.
- `rst` asserted in ACTIVE (sel=2) -> next cycle `ss_n=8'hFF`, `busy=0`; later `xfer_done` produces no activity.
- `xfer_done` pulsed during SETUP (setup=4) -> ignored; `go` still fires on schedule and the block waits in ACTIVE for the real `xfer_done`.
